sd_dat_block_reader: RTL and testbench



---
 rtl/sd_dat_block_reader_if.sv | 11 +
 rtl/sd_dat_block_reader.sv | 168 ++++++++++++++++
 tb/tb_sd_dat_block_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dat_block_reader_if.sv
// sd_dat_block_reader_if: Avalon-MM slave port bundle for the SD DAT block reader.
interface sd_dat_block_reader_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
    modport slave (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/sd_dat_block_reader.sv
// sd_dat_block_reader: captures one 512-byte 4-bit SD DAT block with per-line CRC16 check
// into a 128x32 buffer readable over Avalon-MM.
module sd_dat_block_reader #(
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       reset_n,
    sd_dat_block_reader_if.slave       bus,
    input  logic [3:0]                 sd_dat,
    output logic                       sd_clk
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END_BIT} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic              sd_clk_q, sd_clk_d;
    logic [3:0]        dat_q;
    logic [TW-1:0]     to_q, to_d;
    logic [9:0]        nib_q, nib_d;
    logic [31:0]       asm_q, asm_d;
    logic [6:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0][15:0]  crc_q, crc_d, rx_q, rx_d;
    logic              done_q, done_d, crc_err_q, crc_err_d;
    logic              timeout_q, timeout_d, end_err_q, end_err_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [31:0]       mem [128];
    logic              mem_we, rd, ctrl_wr, abort, start, run, term, tick;
    logic [2:0]        pos;
    logic [31:0]       status;
    logic              unused_wdata;

    assign unused_wdata = ^bus.writedata[31:2];
    assign sd_clk       = sd_clk_q;
    assign bus.readdata = readdata_q;

    always_comb begin
        rd       = bus.chipselect && !bus.read_n;
        ctrl_wr  = bus.chipselect && !bus.write_n && bus.address == 2'd0;
        abort    = ctrl_wr && bus.writedata[1];
        start    = ctrl_wr && bus.writedata[0] && !abort;
        run      = state_q != IDLE;
        term     = div_q == DW'(CLK_DIV - 1);
        tick     = run && term && !sd_clk_q;
        pos      = {nib_q[2:1], ~nib_q[0]};
        status   = {27'b0, end_err_q, timeout_q, crc_err_q, done_q, run};
        div_d    = run ? (term ? '0 : div_q + 1'b1) : '0;
        sd_clk_d = run ? sd_clk_q ^ term : 1'b0;
        state_d   = state_q;
        to_d      = to_q;
        nib_d     = nib_q;
        asm_d     = asm_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = (rd && bus.address == 2'd1) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        crc_d     = crc_q;
        rx_d      = rx_q;
        done_d    = done_q;
        crc_err_d = crc_err_q;
        timeout_d = timeout_q;
        end_err_d = end_err_q;
        mem_we    = 1'b0;
        readdata_d = !rd ? readdata_q :
                     bus.address == 2'd0 ? status :
                     bus.address == 2'd1 ? mem[rd_ptr_q] :
                     bus.address == 2'd2 ? {25'b0, rd_ptr_q} : 32'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d   = WAIT_START;
                {done_d, crc_err_d, timeout_d, end_err_d} = '0;
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                to_d      = '0;
                crc_d     = '0;
            end
            WAIT_START: if (tick) begin
                if (dat_q == 4'h0) begin
                    state_d = DATA;
                    nib_d   = '0;
                end else begin
                    to_d = to_q + 1'b1;
                    if (to_d == TW'(TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            DATA: if (tick) begin
                asm_d[4*pos +: 4] = dat_q;
                for (int i = 0; i < 4; i++)
                    crc_d[i] = {crc_q[i][14:0], 1'b0} ^ ({16{dat_q[i] ^ crc_q[i][15]}} & 16'h1021);
                mem_we   = nib_q[2:0] == 3'd7;
                wr_ptr_d = wr_ptr_q + 7'(mem_we);
                nib_d    = nib_q + 1'b1;
                state_d  = nib_q == 10'd1023 ? CRC : DATA;
            end
            CRC: if (tick) begin
                for (int i = 0; i < 4; i++)
                    rx_d[i] = {rx_q[i][14:0], dat_q[i]};
                nib_d = nib_q + 1'b1;
                if (nib_q == 10'd15) begin
                    state_d   = END_BIT;
                    crc_err_d = rx_d != crc_q;
                end
            end
            END_BIT: if (tick) begin
                end_err_d = dat_q != 4'hF;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort drops the transfer without touching flags or the buffer
        if (abort) begin
            state_d   = IDLE;
            mem_we    = 1'b0;
            wr_ptr_d  = wr_ptr_q;
            done_d    = done_q;
            crc_err_d = crc_err_q;
            timeout_d = timeout_q;
            end_err_d = end_err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            sd_clk_q   <= 1'b0;
            dat_q      <= '0;
            to_q       <= '0;
            nib_q      <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            crc_q      <= '0;
            rx_q       <= '0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            end_err_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sd_clk_q   <= sd_clk_d;
            dat_q      <= sd_dat;
            to_q       <= to_d;
            nib_q      <= nib_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            crc_q      <= crc_d;
            rx_q       <= rx_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            timeout_q  <= timeout_d;
            end_err_q  <= end_err_d;
            readdata_q <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= asm_d;
    end
endmodule

// File: tb/tb_sd_dat_block_reader.sv
// tb_sd_dat_block_reader: random-block checks of the SD DAT reader against a byte/CRC model.
module tb_sd_dat_block_reader;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sd_dat;
    logic       sd_clk;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] blk [512];
    logic [3:0] stream [$];
    logic [31:0] rdv;
    int         idle;

    sd_dat_block_reader_if bus ();

    sd_dat_block_reader #(.CLK_DIV(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .sd_dat(sd_dat), .sd_clk(sd_clk)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
        d = bus.readdata;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    // nibble stream as seen on successive SD_CLK rises: idle, start, data, CRC MSB first, end
    task automatic build(input int n_idle, input int flip_line, input int flip_bit, input logic [3:0] end_nib);
        logic [15:0] crc [4];
        logic [3:0]  nib;
        stream.delete();
        for (int i = 0; i < 4; i++) crc[i] = 16'h0;
        repeat (n_idle) stream.push_back(4'hF);
        stream.push_back(4'h0);
        for (int k = 0; k < 512; k++)
            for (int h = 1; h >= 0; h--) begin
                nib = h ? blk[k][7:4] : blk[k][3:0];
                stream.push_back(nib);
                for (int i = 0; i < 4; i++)
                    crc[i] = (crc[i] << 1) ^ ((nib[i] ^ crc[i][15]) ? 16'h1021 : 16'h0);
            end
        for (int j = 15; j >= 0; j--) begin
            for (int i = 0; i < 4; i++) nib[i] = crc[i][j] ^ (i == flip_line && j == flip_bit);
            stream.push_back(nib);
        end
        stream.push_back(end_nib);
    endtask

    // presents stream[from..upto-1], each one right after an SD_CLK fall
    task automatic send(input int from, input int upto);
        int   idx;
        logic prev;
        logic found;
        for (idx = from; idx < upto; idx++) begin
            prev = sd_clk;
            found = 1'b0;
            for (int n = 0; n < 20 && !found; n++) begin
                @(negedge clk);
                found = prev && !sd_clk;
                prev = sd_clk;
            end
            if (!found) break;
            sd_dat = stream[idx];
        end
        check("stream_sent", idx, upto);
    endtask

    task automatic wait_done();
        logic [31:0] st = 32'h1;
        for (int n = 0; n < 100 && st[0]; n++) bus_rd(2'd0, st);
        check("busy_clear", {31'b0, st[0]}, 32'h0);
        sd_dat = 4'hF;
    endtask

    task automatic start_block();
        sd_dat = stream[0];
        bus_wr(2'd0, 32'h1);
    endtask

    task automatic check_words();
        logic [31:0] w;
        for (int i = 0; i < 128; i++) begin
            bus_rd(2'd1, w);
            check("data_word", w, {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]});
        end
        bus_rd(2'd2, w);
        check("rdptr_wrap", w, 32'h0);
    endtask

    task automatic rand_block();
        for (int k = 0; k < 512; k++) blk[k] = 8'($urandom);
        idle = $urandom_range(0, 10);
    endtask

    initial begin
        int rises, t1, t2, cyc;
        logic prev;
        logic [31:0] st;
        bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
        bus.address = 2'd0; bus.writedata = 32'h0;
        sd_dat = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_sd_clk", {31'b0, sd_clk}, 32'h0);
        reset_n = 1'b1;
        bus_rd(2'd0, rdv);
        check("reset_status", rdv, 32'h0);
        bus_rd(2'd2, rdv);
        check("reset_rdptr", rdv, 32'h0);

        // counting-pattern block, good CRC and end bit
        for (int k = 0; k < 512; k++) blk[k] = 8'(k);
        build(5, -1, 0, 4'hF);
        start_block();
        send(1, stream.size());
        wait_done();
        bus_rd(2'd0, rdv);
        check("good_status", rdv, 32'h2);
        bus_rd(2'd1, rdv);
        check("first_word", rdv, 32'h03020100);
        for (int i = 1; i < 127; i++) bus_rd(2'd1, rdv);
        bus_rd(2'd1, rdv);
        check("last_word", rdv, 32'hFFFEFDFC);
        bus_rd(2'd2, rdv);
        check("rdptr_after_128", rdv, 32'h0);

        // DAT2 CRC bit 5 corrupted
        build(5, 2, 5, 4'hF);
        start_block();
        send(1, stream.size());
        wait_done();
        bus_rd(2'd0, rdv);
        check("crc_err_status", rdv, 32'h6);
        check_words();

        // bad end nibble
        build(5, -1, 0, 4'hE);
        start_block();
        send(1, stream.size());
        wait_done();
        bus_rd(2'd0, rdv);
        check("end_err_status", rdv, 32'h12);
        check_words();

        // timeout with DAT idle high, plus SD_CLK period
        sd_dat = 4'hF;
        bus_wr(2'd0, 32'h1);
        rises = 0; t1 = 0; t2 = 0; cyc = 0; prev = sd_clk; st = 32'h1;
        for (int n = 0; n < 400; n++) begin
            bus_rd(2'd0, st);
            cyc++;
            if (!prev && sd_clk) begin
                rises++;
                if (rises == 1) t1 = cyc;
                if (rises == 2) t2 = cyc;
            end
            prev = sd_clk;
            if (st[3]) break;
        end
        check("timeout_rises", rises, 64);
        check("sd_clk_period", t2 - t1, 4);
        check("timeout_status", st, 32'h8);
        @(negedge clk);
        check("timeout_sd_clk_low", {31'b0, sd_clk}, 32'h0);

        // abort after 100 data nibbles
        rand_block();
        build(idle, -1, 0, 4'hF);
        start_block();
        send(1, idle + 1 + 100);
        bus_wr(2'd0, 32'h3);
        bus_rd(2'd0, rdv);
        check("abort_status", rdv, 32'h0);
        @(negedge clk);
        check("abort_sd_clk_low", {31'b0, sd_clk}, 32'h0);

        // second start mid-transfer must be ignored
        rand_block();
        build(idle, -1, 0, 4'hF);
        start_block();
        send(1, idle + 1 + 200);
        bus_wr(2'd0, 32'h1);
        send(idle + 1 + 200, stream.size());
        wait_done();
        bus_rd(2'd0, rdv);
        check("restart_ignored_status", rdv, 32'h2);
        check_words();

        // async reset in the middle of DATA
        rand_block();
        build(idle, -1, 0, 4'hF);
        start_block();
        send(1, idle + 1 + 300);
        bus_rd(2'd0, rdv);
        check("busy_mid_data", rdv, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_sd_clk", {31'b0, sd_clk}, 32'h0);
        check("async_rst_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        sd_dat = 4'hF;
        bus_rd(2'd0, rdv);
        check("post_rst_status", rdv, 32'h0);

        for (int r = 0; r < 2; r++) begin
            rand_block();
            build(idle, -1, 0, 4'hF);
            start_block();
            send(1, stream.size());
            wait_done();
            bus_rd(2'd0, rdv);
            check("rand_status", rdv, 32'h2);
            check_words();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
